// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event word layout
// for the PS/2 Set-2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  localparam int EV_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE_E0,
    ST_PRE_F0,
    ST_PRE_E0F0
  } ps2_state_e;

  // {ext[9], rel[8], code[7:0]}
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_prefix(
    input logic [7:0] b
  );
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO; head is always on dout.
// A pop frees a slot for a push in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int W      = 10
) (
  input  logic              inclock,
  input  logic              resetn,
  input  logic              push,
  input  logic [W-1:0]      din,
  input  logic              pop,
  output logic [W-1:0]      dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              do_pop;
  logic              do_push;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge inclock) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Folds PS/2 Set-2 E0/F0 prefixes into key events,
// filters typematic repeats and queues events in a FIFO.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic            inclock,
  input  logic            resetn,
  input  logic [7:0]      key_data,
  input  logic            key_strobe,
  input  logic            rd_en,
  input  logic            ov_clear,
  output logic            ev_valid,
  output logic [7:0]      ev_code,
  output logic            ev_release,
  output logic            ev_extended,
  output logic [ADDR_W:0] ev_count,
  output logic            overflow,
  output logic            proto_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e      state;
  ps2_state_e      state_n;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic            emit;
  logic            err;
  ps2_event_t      ev_n;

  logic            held_vld;
  logic            held_ext;
  logic [7:0]      held_code;
  logic            ev_match;
  logic            make_hit;

  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [EV_W-1:0] head;
  ps2_event_t      head_ev;

  always_ff @(posedge inclock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  assign timeout = (state != ST_IDLE) && !key_strobe
                && (to_cnt == TO_LAST);

  always_comb begin
    state_n = state;
    emit    = 1'b0;
    err     = 1'b0;
    ev_n    = '0;
    ev_n.code = key_data;
    if (key_strobe) begin
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            key_data == PS2_EXT: state_n = ST_PRE_E0;
            key_data == PS2_BRK: state_n = ST_PRE_F0;
            key_data == PS2_ERR0,
            key_data == PS2_ERR1,
            key_data == PS2_PAUSE: ;
            default: emit = 1'b1;
          endcase
        end
        ST_PRE_E0: begin
          unique case (1'b1)
            key_data == PS2_BRK: state_n = ST_PRE_E0F0;
            key_data == PS2_EXT: ;
            default: begin
              emit     = 1'b1;
              ev_n.ext = 1'b1;
              state_n  = ST_IDLE;
            end
          endcase
        end
        ST_PRE_F0: begin
          state_n = ST_IDLE;
          if (is_prefix(key_data)) begin
            err = 1'b1;
          end else begin
            emit     = 1'b1;
            ev_n.rel = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          if (is_prefix(key_data)) begin
            err = 1'b1;
          end else begin
            emit     = 1'b1;
            ev_n.ext = 1'b1;
            ev_n.rel = 1'b1;
          end
        end
      endcase
    end else if (timeout) begin
      state_n = ST_IDLE;
      err     = 1'b1;
    end
  end

  // Idle time is only measured while a prefix is pending
  always_ff @(posedge inclock) begin
    if (!resetn)
      to_cnt <= '0;
    else if (key_strobe || timeout || state == ST_IDLE)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign ev_match = held_vld
                 && (held_ext == ev_n.ext)
                 && (held_code == ev_n.code);
  assign make_hit = (FILTER_REPEAT != 0)
                 && ev_match && !ev_n.rel;
  assign push     = emit && !make_hit;

  always_ff @(posedge inclock) begin
    if (!resetn) begin
      held_vld  <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= '0;
    end else if (emit) begin
      if (!ev_n.rel && !ev_match) begin
        held_vld  <= 1'b1;
        held_ext  <= ev_n.ext;
        held_code <= ev_n.code;
      end else if (ev_n.rel && ev_match) begin
        held_vld <= 1'b0;
      end
    end
  end

  assign pop = rd_en && !empty;

  ps2_event_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (EV_W)
  ) u_fifo (
    .inclock (inclock),
    .resetn  (resetn),
    .push    (push),
    .din     (ev_n),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (ev_count)
  );

  always_ff @(posedge inclock) begin
    if (!resetn)
      overflow <= 1'b0;
    else if (push && full && !pop)
      overflow <= 1'b1;
    else if (ov_clear)
      overflow <= 1'b0;
  end

  always_ff @(posedge inclock) begin
    if (!resetn) proto_err <= 1'b0;
    else         proto_err <= err;
  end

  // Head is forced to zero when empty so outputs never carry stale data
  assign head_ev     = empty ? '0 : ps2_event_t'(head);
  assign ev_valid    = !empty;
  assign ev_code     = head_ev.code;
  assign ev_release  = head_ev.rel;
  assign ev_extended = head_ev.ext;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench: table of byte sequences plus hand
// sequences for filter, overflow, timeout and reset.
module tb_ps2_key_event_decoder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 20;

  logic          inclock = 1'b0;
  logic          resetn;
  logic [7:0]    key_data;
  logic          key_strobe;
  logic          rd_en;
  logic          ov_clear;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_release;
  logic          ev_extended;
  logic [AW:0]   ev_count;
  logic          overflow;
  logic          proto_err;

  int errors = 0;
  int checks = 0;
  int perr_cnt = 0;

  ps2_key_event_decoder #(
    .DEPTH          (DEPTH),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO),
    .FILTER_REPEAT  (1)
  ) dut (
    .inclock     (inclock),
    .resetn      (resetn),
    .key_data    (key_data),
    .key_strobe  (key_strobe),
    .rd_en       (rd_en),
    .ov_clear    (ov_clear),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_release  (ev_release),
    .ev_extended (ev_extended),
    .ev_count    (ev_count),
    .overflow    (overflow),
    .proto_err   (proto_err)
  );

  always #5 inclock = ~inclock;

  always @(negedge inclock)
    if (proto_err === 1'b1) perr_cnt++;

  typedef struct {
    int          nb;
    logic [23:0] bytes;
    logic        has;
    logic        ext;
    logic        rel;
    logic [7:0]  code;
    int          err;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge inclock);
    key_data   = b;
    key_strobe = 1'b1;
    @(negedge inclock);
    key_strobe = 1'b0;
  endtask

  task automatic pop1();
    @(negedge inclock);
    rd_en = 1'b1;
    @(negedge inclock);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge inclock);
    resetn = 1'b0;
    @(negedge inclock);
    @(negedge inclock);
    resetn = 1'b1;
  endtask

  task automatic check_head(input string nm,
                            input logic ext,
                            input logic rel,
                            input logic [7:0] code);
    check({nm, ".valid"}, 32'(ev_valid), 32'(1'b1));
    check({nm, ".head"},
          32'({ev_extended, ev_release, ev_code}),
          32'({ext, rel, code}));
  endtask

  initial begin
    int p0;
    resetn     = 1'b0;
    key_data   = '0;
    key_strobe = 1'b0;
    rd_en      = 1'b0;
    ov_clear   = 1'b0;

    vt[0]  = '{1, 24'h1C0000, 1, 0, 0, 8'h1C, 0};
    vt[1]  = '{2, 24'hE07500, 1, 1, 0, 8'h75, 0};
    vt[2]  = '{3, 24'hE0F075, 1, 1, 1, 8'h75, 0};
    vt[3]  = '{2, 24'hF01C00, 1, 0, 1, 8'h1C, 0};
    vt[4]  = '{1, 24'h000000, 0, 0, 0, 8'h00, 0};
    vt[5]  = '{1, 24'hFF0000, 0, 0, 0, 8'h00, 0};
    vt[6]  = '{1, 24'hE10000, 0, 0, 0, 8'h00, 0};
    vt[7]  = '{2, 24'hF0E000, 0, 0, 0, 8'h00, 1};
    vt[8]  = '{3, 24'hE0E01C, 1, 1, 0, 8'h1C, 0};
    vt[9]  = '{3, 24'hE0F0F0, 0, 0, 0, 8'h00, 1};
    vt[10] = '{1, 24'h5A0000, 1, 0, 0, 8'h5A, 0};

    do_reset();
    @(negedge inclock);
    check("rst.valid", 32'(ev_valid), 32'(1'b0));
    check("rst.count", 32'(ev_count), 32'd0);
    check("rst.ovf", 32'(overflow), 32'(1'b0));
    check("rst.perr", 32'(proto_err), 32'(1'b0));
    check("rst.code", 32'(ev_code), 32'd0);

    for (int i = 0; i < 11; i++) begin
      p0 = perr_cnt;
      for (int k = 0; k < vt[i].nb; k++)
        send(vt[i].bytes[23-8*k -: 8]);
      check($sformatf("v%0d.valid", i),
            32'(ev_valid), 32'(vt[i].has));
      @(negedge inclock);
      check($sformatf("v%0d.count", i),
            32'(ev_count), 32'(vt[i].has));
      check($sformatf("v%0d.perr", i),
            32'(perr_cnt - p0), 32'(vt[i].err));
      if (vt[i].has) begin
        check_head($sformatf("v%0d", i),
                   vt[i].ext, vt[i].rel, vt[i].code);
        pop1();
      end
    end

    // Typematic filter
    do_reset();
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    send(8'h1C);
    check("flt.count", 32'(ev_count), 32'd3);
    check_head("flt0", 1'b0, 1'b0, 8'h1C);
    pop1();
    check_head("flt1", 1'b0, 1'b1, 8'h1C);
    pop1();
    check_head("flt2", 1'b0, 1'b0, 8'h1C);
    pop1();
    check("flt.empty", 32'(ev_valid), 32'(1'b0));

    // Overflow, clear, full push+pop, drain
    do_reset();
    for (int i = 0; i < 9; i++)
      send(8'h10 + 8'(i));
    check("ovf.count", 32'(ev_count), 32'd8);
    check("ovf.set", 32'(overflow), 32'(1'b1));
    @(negedge inclock);
    ov_clear = 1'b1;
    @(negedge inclock);
    ov_clear = 1'b0;
    check("ovf.clr", 32'(overflow), 32'(1'b0));
    @(negedge inclock);
    key_data   = 8'h20;
    key_strobe = 1'b1;
    rd_en      = 1'b1;
    @(negedge inclock);
    key_strobe = 1'b0;
    rd_en      = 1'b0;
    check("fpp.count", 32'(ev_count), 32'd8);
    check("fpp.ovf", 32'(overflow), 32'(1'b0));
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i), 1'b0, 1'b0,
                 (i == 7) ? 8'h20 : 8'h11 + 8'(i));
      pop1();
    end
    check("drain.count", 32'(ev_count), 32'd0);

    // Prefix timeout
    do_reset();
    p0 = perr_cnt;
    send(8'hF0);
    repeat (TO - 2) @(negedge inclock);
    check("to.early", 32'(perr_cnt - p0), 32'd0);
    repeat (3) @(negedge inclock);
    check("to.pulse", 32'(perr_cnt - p0), 32'd1);
    send(8'h1C);
    check_head("to.next", 1'b0, 1'b0, 8'h1C);
    pop1();

    // Reset mid-prefix
    send(8'hE0);
    do_reset();
    send(8'h75);
    check_head("rstpre", 1'b0, 1'b0, 8'h75);
    check("rstpre.count", 32'(ev_count), 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
